// File: rtl/controlador_alertas.sv
//==============================================================================
// Module  : controlador_alertas
// Brief   : Qualifies and latches decoder alarm levels into timed, registered
//           buzzer / indicator / ventilator / light commands.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module controlador_alertas #(
    parameter int DIV        = 50000,
    parameter int N_VALID    = 4,
    parameter int T_GRAVE    = 2,
    parameter int T_LEVE     = 8,
    parameter int T_SILENCIO = 16,
    parameter int T_VENT_MIN = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       AlarmSonGrave,
    input  logic       AlarmSonLeve,
    input  logic       Ventilacion,
    input  logic       Iluminacion,
    input  logic       Reconocer,
    output logic       Zumbador,
    output logic       LedGrave,
    output logic       LedLeve,
    output logic       Ventilador,
    output logic       Luz,
    output logic [1:0] Estado
);

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        LEVE     = 2'd1,
        GRAVE    = 2'd2,
        SILENCIO = 2'd3
    } estado_t;

    localparam logic [15:0] c_div_last = 16'(DIV - 1);
    localparam logic [15:0] c_nvalid   = 16'(N_VALID);
    localparam logic [15:0] c_tg_last  = 16'(T_GRAVE - 1);
    localparam logic [15:0] c_tl_last  = 16'(T_LEVE - 1);
    localparam logic [15:0] c_sil_last = 16'(T_SILENCIO - 1);
    localparam logic [15:0] c_vent_min = 16'(T_VENT_MIN);

    logic [15:0] r_pre;
    logic [15:0] r_gcnt;
    logic [15:0] r_lcnt;
    logic [15:0] r_sil;
    logic [15:0] r_cad;
    logic [15:0] r_hold;
    estado_t     r_state;
    estado_t     w_next;
    logic        r_sev_grave;
    logic        w_next_sev_grave;
    logic        w_tick;
    logic        w_gq;
    logic        w_lq;
    logic        w_next_alarm;
    logic        w_entry;
    logic [15:0] w_cad_last;

    assign w_tick = (r_pre == c_div_last);
    assign w_gq   = (r_gcnt == c_nvalid);
    assign w_lq   = (r_lcnt == c_nvalid);
    assign Estado = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre  <= 16'd0;
            r_gcnt <= 16'd0;
            r_lcnt <= 16'd0;
        end else begin
            r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
            if (w_tick) begin
                if (!AlarmSonGrave)
                    r_gcnt <= 16'd0;
                else if (r_gcnt != c_nvalid)
                    r_gcnt <= r_gcnt + 16'd1;
                if (!AlarmSonLeve)
                    r_lcnt <= 16'd0;
                else if (r_lcnt != c_nvalid)
                    r_lcnt <= r_lcnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= REPOSO;
            r_sev_grave <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_sev_grave <= w_next_sev_grave;
        end
    end

    // sev only changes on entry to SILENCIO; the alarm stays latched otherwise
    always_comb begin
        w_next           = r_state;
        w_next_sev_grave = r_sev_grave;
        case (r_state)
            REPOSO: begin
                if (w_gq)
                    w_next = GRAVE;
                else if (w_lq)
                    w_next = LEVE;
            end
            LEVE: begin
                if (w_gq) begin
                    w_next = GRAVE;
                end else if (Reconocer) begin
                    w_next           = SILENCIO;
                    w_next_sev_grave = 1'b0;
                end
            end
            GRAVE: begin
                if (Reconocer) begin
                    w_next           = SILENCIO;
                    w_next_sev_grave = 1'b1;
                end
            end
            SILENCIO: begin
                if (!r_sev_grave && w_gq)
                    w_next = GRAVE;
                else if (w_tick && (r_sil == c_sil_last))
                    w_next = REPOSO;
            end
            default: w_next = REPOSO;
        endcase
    end

    assign w_next_alarm = (w_next == LEVE) || (w_next == GRAVE);
    assign w_entry      = w_next_alarm && (w_next != r_state);
    assign w_cad_last   = (r_state == GRAVE) ? c_tg_last : c_tl_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sil    <= 16'd0;
            r_cad    <= 16'd0;
            Zumbador <= 1'b0;
            LedGrave <= 1'b0;
            LedLeve  <= 1'b0;
        end else begin
            LedGrave <= (w_next == GRAVE) || ((w_next == SILENCIO) && w_next_sev_grave);
            LedLeve  <= (w_next == LEVE)  || ((w_next == SILENCIO) && !w_next_sev_grave);

            if ((r_state == SILENCIO) && (w_next == SILENCIO)) begin
                if (w_tick)
                    r_sil <= r_sil + 16'd1;
            end else begin
                r_sil <= 16'd0;
            end

            if (w_entry) begin
                Zumbador <= 1'b1;
                r_cad    <= 16'd0;
            end else if (w_next_alarm) begin
                if (w_tick) begin
                    if (r_cad == w_cad_last) begin
                        Zumbador <= ~Zumbador;
                        r_cad    <= 16'd0;
                    end else begin
                        r_cad <= r_cad + 16'd1;
                    end
                end
            end else begin
                Zumbador <= 1'b0;
                r_cad    <= 16'd0;
            end
        end
    end

    // Hold time restarts while the request is present, so the minimum applies after release
    always_ff @(posedge clk) begin
        if (reset) begin
            Ventilador <= 1'b0;
            r_hold     <= 16'd0;
            Luz        <= 1'b0;
        end else begin
            Luz <= Iluminacion;
            if (Ventilacion) begin
                Ventilador <= 1'b1;
                r_hold     <= 16'd0;
            end else if (Ventilador) begin
                if (r_hold == c_vent_min)
                    Ventilador <= 1'b0;
                else if (w_tick)
                    r_hold <= r_hold + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire
